// File: rtl/adder_pkg.sv
// Shared constants, operation mode and parameter sanity check for the
// pipelined adder/subtractor.
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;

  function automatic bit width_ok(int w, int c);
    return (c >= 1) && (c <= w) && ((w % c) == 0);
  endfunction
endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Upstream (operands) and downstream (result) handshakes of the pipelined adder.
interface pipelined_adder_nbit_if import adder_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_chunk.sv
// Full-adder cell and the CHUNK-bit combinational ripple built from it; also
// exposes the carry into the chunk MSB so the last rank can derive overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit adder/subtractor resolving CHUNK bits per rank, with a
// bubble-collapsing valid/ready pipeline; outputs come straight from registers.
module pipelined_adder_nbit import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_adder_nbit_if.slave bus
);
  localparam int NUM_STAGES = WIDTH / CHUNK;

  if (!width_ok(WIDTH, CHUNK)) begin : g_param_chk
    $error("pipelined_adder_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  mode_e mode;
  assign mode = mode_e'(bus.sub);

  // Rank registers, indexed 1..NUM_STAGES. x_r carries the result in its low
  // (processed) chunks and still-unprocessed operand A in its high chunks.
  logic [NUM_STAGES:1]            vld_pipe;
  logic [NUM_STAGES:1]            adv;
  logic [NUM_STAGES:1][WIDTH-1:0] x_r;
  logic [NUM_STAGES:1][WIDTH-1:0] y_r;
  logic [NUM_STAGES:1]            c_r;
  logic                           cm_r;

  // Per-chunk source view: index 0 is the input port, index k is rank k.
  logic [NUM_STAGES-1:0]            sv, sc, co, cm;
  logic [NUM_STAGES-1:0][WIDTH-1:0] sx, sy, nx;
  logic [NUM_STAGES-1:0][CHUNK-1:0] cs;

  always_comb begin
    sv[0] = bus.in_valid;
    sx[0] = bus.a;
    sy[0] = (mode == SUB) ? ~bus.b : bus.b;
    sc[0] = (mode == SUB) | bus.cin;
    for (int k = 1; k < NUM_STAGES; k++) begin
      sv[k] = vld_pipe[k];
      sx[k] = x_r[k];
      sy[k] = y_r[k];
      sc[k] = c_r[k];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_chunk
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (sx[g][g*CHUNK +: CHUNK]),
      .b    (sy[g][g*CHUNK +: CHUNK]),
      .cin  (sc[g]),
      .s    (cs[g]),
      .cout (co[g]),
      .cmsb (cm[g])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      nx[k]                    = sx[k];
      nx[k][k*CHUNK +: CHUNK]  = cs[k];
    end
  end

  // A rank moves when it is empty or its successor moves; this ripples
  // combinationally from out_ready back to in_ready.
  always_comb begin
    logic go;
    go  = !vld_pipe[NUM_STAGES] || bus.out_ready;
    adv = '0;
    adv[NUM_STAGES] = go;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      go     = !vld_pipe[k] || go;
      adv[k] = go;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x_r      <= '0;
      y_r      <= '0;
      c_r      <= '0;
      cm_r     <= 1'b0;
    end else begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= sv[k-1];
          if (sv[k-1]) begin
            x_r[k] <= nx[k-1];
            y_r[k] <= sy[k-1];
            c_r[k] <= co[k-1];
          end
        end
      end
      if (adv[NUM_STAGES] && sv[NUM_STAGES-1])
        cm_r <= cm[NUM_STAGES-1];
    end
  end

  assign bus.in_ready  = adv[1];
  assign bus.out_valid = vld_pipe[NUM_STAGES];
  assign bus.sum       = x_r[NUM_STAGES];
  assign bus.cout      = c_r[NUM_STAGES];
  assign bus.ovf       = c_r[NUM_STAGES] ^ cm_r;
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Randomized and directed checks of pipelined_adder_nbit at three geometries
// against an arithmetic reference model with in-order scoreboards.
module tb_pipelined_adder_nbit;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_adder_nbit_if #(.WIDTH(16)) b16 ();
  pipelined_adder_nbit_if #(.WIDTH(4))  b4 ();
  pipelined_adder_nbit_if #(.WIDTH(8))  b8 ();

  pipelined_adder_nbit #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  pipelined_adder_nbit #(.WIDTH(4),  .CHUNK(4)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  pipelined_adder_nbit #(.WIDTH(8),  .CHUNK(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    exp_t   e;
    longint m  = longint'(1) << w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint r, sr;
    if (sub) begin
      r   = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
      r   = (r + m) % m;
    end else begin
      r   = ua + ub + longint'(cin);
      sr  = sa + sb + longint'(cin);
      e.c = (r >= m);
      r   = r % m;
    end
    e.s = 16'(r);
    e.o = (sr < -(m / 2)) || (sr >= m / 2);
    return e;
  endfunction

  // Scoreboard for the 16-bit instance, plus hold-while-stalled checks.
  logic        p_v = 1'b0, p_r = 1'b0, p_c = 1'b0, p_o = 1'b0;
  logic [15:0] p_s = '0;
  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n) begin
      if (p_v && !p_r) begin
        chk("d16 hold sum", 32'(b16.sum), 32'(p_s));
        chk("d16 hold cout", 32'(b16.cout), 32'(p_c));
        chk("d16 hold ovf", 32'(b16.ovf), 32'(p_o));
      end
      if (b16.out_valid && b16.out_ready) begin
        if (q16.size() == 0) chk("d16 spurious out", 32'(b16.out_valid), 32'd0);
        else begin
          e = q16.pop_front();
          chk("d16 sb sum", 32'(b16.sum), 32'(e.s));
          chk("d16 sb cout", 32'(b16.cout), 32'(e.c));
          chk("d16 sb ovf", 32'(b16.ovf), 32'(e.o));
        end
      end
      if (b16.in_valid && b16.in_ready)
        q16.push_back(model(16, b16.a, b16.b, b16.cin, b16.sub));
    end
    p_v <= rst_n && b16.out_valid;
    p_r <= b16.out_ready;
    p_s <= b16.sum;
    p_c <= b16.cout;
    p_o <= b16.ovf;
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n) begin
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) chk("d8 spurious out", 32'(b8.out_valid), 32'd0);
        else begin
          e = q8.pop_front();
          chk("d8 sb sum", 32'(b8.sum), 32'(e.s));
          chk("d8 sb cout", 32'(b8.cout), 32'(e.c));
          chk("d8 sb ovf", 32'(b8.ovf), 32'(e.o));
        end
      end
      if (b8.in_valid && b8.in_ready)
        q8.push_back(model(8, 16'(b8.a), 16'(b8.b), b8.cin, b8.sub));
    end
  end

  task automatic drive(int which, logic v, logic [15:0] a, logic [15:0] b, logic ci, logic su);
    case (which)
      0: begin b16.in_valid = v; b16.a = a;      b16.b = b;      b16.cin = ci; b16.sub = su; end
      1: begin b4.in_valid  = v; b4.a  = a[3:0]; b4.b  = b[3:0]; b4.cin  = ci; b4.sub  = su; end
      default: begin b8.in_valid = v; b8.a = a[7:0]; b8.b = b[7:0]; b8.cin = ci; b8.sub = su; end
    endcase
  endtask

  function automatic logic [18:0] outs(int which);
    case (which)
      0:       return {b16.out_valid, b16.ovf, b16.cout, b16.sum};
      1:       return {b4.out_valid, b4.ovf, b4.cout, 12'h000, b4.sum};
      default: return {b8.out_valid, b8.ovf, b8.cout, 8'h00, b8.sum};
    endcase
  endfunction

  // One isolated transaction: checks latency and the result fields.
  task automatic run_one(int which, string tag, logic [15:0] a, logic [15:0] b, logic ci, logic su,
                         logic [15:0] es, logic ec, logic eo, int exp_lat);
    int          lat;
    logic [18:0] o;
    @(posedge clk); #1;
    drive(which, 1'b1, a, b, ci, su);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin #1; drive(which, 1'b0, a, b, ci, su); end
      @(negedge clk);
      o = outs(which);
    end while (!o[18] && lat < 30);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " sum"}, 32'(o[15:0]), 32'(es));
    chk({tag, " cout"}, 32'(o[16]), 32'(ec));
    chk({tag, " ovf"}, 32'(o[17]), 32'(eo));
  endtask

  initial begin
    exp_t        e;
    logic [15:0] ia[8], ib[8], ra, rb;
    logic        rc, rs;
    int          sent, pops, first, last;

    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0, 1'b0);
    b16.out_ready = 1'b1; b4.out_ready = 1'b1; b8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", 32'(b16.out_valid), 32'd0);
    chk("reset sum", 32'(b16.sum), 32'd0);
    chk("reset cout", 32'(b16.cout), 32'd0);
    chk("reset ovf", 32'(b16.ovf), 32'd0);
    chk("reset d4 out_valid", 32'(b4.out_valid), 32'd0);
    chk("reset d8 out_valid", 32'(b8.out_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready d16", 32'(b16.in_ready), 32'd1);
    chk("post-reset in_ready d8", 32'(b8.in_ready), 32'd1);

    run_one(0, "add 3+3+1", 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, 4);
    run_one(0, "carry ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    run_one(0, "ovf 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    run_one(0, "sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    run_one(0, "sub 8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
    run_one(1, "d4 f+7+1", 16'h000F, 16'h0007, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 1);
    run_one(1, "d4 3-5", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255));
      rc = 1'($urandom); rs = 1'($urandom);
      e = model(8, ra, rb, rc, rs);
      run_one(2, "d8 rnd", ra, rb, rc, rs, e.s, e.c, e.o, 8);
    end

    // Backpressure: 8 back-to-back operands, out_ready low in cycles 3..6.
    for (int i = 0; i < 8; i++) begin ia[i] = 16'($urandom); ib[i] = 16'($urandom); end
    sent = 0; pops = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      b16.out_ready = !(c >= 3 && c <= 6);
      drive(0, sent < 8, ia[sent % 8], ib[sent % 8], 1'($urandom), 1'($urandom));
      @(negedge clk);
      if (c == 4) chk("bp in_ready full", 32'(b16.in_ready), 32'd0);
      if (c == 7) chk("bp in_ready release", 32'(b16.in_ready), 32'd1);
      if (b16.in_valid && b16.in_ready) sent++;
      if (b16.out_valid && b16.out_ready) begin
        pops++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("bp accepted", 32'(sent), 32'd8);
    chk("bp popped", 32'(pops), 32'd8);
    chk("bp first pop", 32'(first), 32'd7);
    chk("bp pop span", 32'(last - first), 32'd7);

    // Random traffic with random backpressure on both 16- and 8-bit instances.
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      drive(0, 1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      drive(2, 1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      b16.out_ready = 1'($urandom_range(3) != 0);
      b8.out_ready  = 1'($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0, 1'b0);
    b16.out_ready = 1'b1; b8.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("d16 drain", 32'(q16.size()), 32'd0);
    chk("d8 drain", 32'(q8.size()), 32'd0);

    // Reset in the middle of a 4-deep stream with the head stalled.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c < 4) drive(0, 1'b1, 16'h1234 + 16'(c), 16'h4321, 1'b0, 1'b0);
      else begin drive(0, 1'b0, '0, '0, 1'b0, 1'b0); b16.out_ready = 1'b0; end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(b16.out_valid), 32'd0);
    chk("midreset sum", 32'(b16.sum), 32'd0);
    chk("midreset cout", 32'(b16.cout), 32'd0);
    chk("midreset ovf", 32'(b16.ovf), 32'd0);
    q16.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b16.out_ready = 1'b1;
    @(negedge clk);
    chk("midreset in_ready", 32'(b16.in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midreset no stale", 32'(b16.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides. Each pipeline rank resolves one CHUNK-bit slice of the operands with a ripple of full adders and registers the carry forward. This gives full throughput at a clock rate independent of WIDTH. It generalises the team's fixed 4-bit ripple adder for datapaths that need wide operands, subtraction, overflow detection and backpressure.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline rank; 1 ≤ CHUNK ≤ WIDTH.
- NUM_STAGES, WIDTH/CHUNK: derived localparam; equals latency in cycles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Transfer in: in_valid && in_ready sampled at a rising edge. Transfer out: out_valid && out_ready.
- sub is applied at entry: b is inverted and the effective carry-in is forced to 1. Inverted b and the effective carry travel with the transaction.
- Rank k (1..NUM_STAGES) holds:
  - valid bit;
  - result bits [k·CHUNK−1:0];
  - carry out of bit k·CHUNK−1;
  - carry into bit k·CHUNK−1, retained only in the last rank for ovf;
  - unprocessed operand bits [WIDTH−1:k·CHUNK].
- Chunk 0 is added combinationally on the input. Chunk k is added between rank k and rank k+1.
- Rank NUM_STAGES drives sum/cout/ovf/out_valid directly from registers. There is no combinational path from inputs to outputs.
- Bubble-collapsing flow control: rank k advances iff rank k is empty or rank k+1 advances. The last rank advances iff empty or out_ready.
- in_ready = rank 1 advances. This is combinational from out_ready through the rank chain.
- While out_valid && !out_ready, sum/cout/ovf are held stable.
- Transactions exit in acceptance order. None is dropped or duplicated.

## Timing
- Latency: a transaction accepted in cycle 0 shows out_valid in cycle NUM_STAGES when there are no stalls.
- Throughput: one transaction per cycle while out_ready=1.
- Reset (rst_n low, asynchronous) clears:
  - all valid bits and data registers;
  - out_valid=0, sum=0, cout=0, ovf=0.
- in_ready=1 from the first cycle after reset release.
- Reset mid-operation discards all in-flight transactions. Nothing is emitted afterwards.
- When all ranks are full and out_ready=0, in_ready=0. It returns to 1 in the same cycle out_ready rises.
- Simultaneous output pop and input accept with all ranks full is legal and sustains full rate.
- NUM_STAGES=1 degenerates to one registered WIDTH-bit ripple with latency 1.

## Structure
- Shared package adder_pkg holds:
  - default WIDTH/CHUNK constants;
  - a mode enum, ADD=0 and SUB=1, used for sub;
  - an elaboration-time check function that WIDTH % CHUNK == 0.
- One sub-module, adder_chunk: CHUNK-bit combinational ripple of the existing full-adder cell. It takes a, b, cin and returns s, cout, plus the carry into its MSB for ovf.
- Instantiate adder_chunk once per rank via generate. Rank registers live in the top module.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated otherwise.
- Reset: assert rst_n low during a 4-deep stream → out_valid=0, sum=0, cout=0, ovf=0 immediately. in_ready=1 the cycle after release; no stale result ever appears.
- Basic add: a=16'h0003, b=16'h0003, cin=1, sub=0 → sum=16'h0007, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- Full-length carry: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0. a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (must be ignored) → sum=16'hFFFE, cout=0, ovf=0. a=16'h8000, b=16'h0001, sub=1 → sum=16'h7FFF, cout=1, ovf=1.
- Backpressure: 8 back-to-back random transactions with out_ready=0 in cycles 3–6 → in_ready falls once 4 ranks fill. Outputs stay stable while stalled; all 8 results match the reference model in order at one per cycle after release.
- Parameter sweep:
  - WIDTH=4, CHUNK=4: a=4'b1111, b=4'b0111, cin=1 → sum=4'b0111, cout=1, latency 1.
  - WIDTH=8, CHUNK=1: random add/sub against the model, latency 8.
